// File: rtl/cpu_sequencer_if.sv
// Instruction-fetch handshake between cpu_sequencer (master) and program memory (slave).
interface cpu_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [15:0]       mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit accumulator core.
// Build option SINGLE_STEP_EN: hold in PAUSE after each instruction until a rising edge on step.
module cpu_sequencer #(
  parameter int                ADDR_W        = 8,
  parameter logic [ADDR_W-1:0] RESET_PC      = '0,
  parameter int                FETCH_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  cpu_sequencer_if.master    mem,
  input  logic               zero_flag,
  input  logic               step,
  output logic [ADDR_W-1:0]  pc,
  output logic [7:0]         operand,
  output logic [2:0]         alu_op,
  output logic               acc_load,
  output logic               halted,
  output logic               fault,
  output logic [15:0]        instr_retired
);
  // state  | meaning
  // IDLE   | waiting for run
  // FETCH  | mem_req high, waiting for mem_ack (bounded by FETCH_TIMEOUT)
  // DECODE | IR settled, acc_load armed for EXEC
  // EXEC   | pc/retire update, acc_load high for ALU ops
  // HALT   | HLT executed, absorbing until reset
  // FAULT  | fetch timed out, absorbing until reset
  // PAUSE  | single-step hold (SINGLE_STEP_EN only)
  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXEC, HALT, FAULT
`ifdef SINGLE_STEP_EN
    , PAUSE
`endif
  } state_t;

  localparam logic [3:0] OP_LOAD = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_JMP  = 4'h4;
  localparam logic [3:0] OP_JZ   = 4'h5;
  localparam logic [3:0] OP_HLT  = 4'hF;

  localparam bit              TO_EN   = (FETCH_TIMEOUT > 0);
  localparam int              TO_W    = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'((FETCH_TIMEOUT > 0) ? FETCH_TIMEOUT - 1 : 0);

  state_t            state;
  logic [15:0]       ir;
  logic              req_q;
  logic [TO_W-1:0]   wait_cnt;
  logic [3:0]        opcode;
  logic [ADDR_W-1:0] next_pc;
  logic [3:0]        unused_ir;

  assign opcode       = ir[15:12];
  assign operand      = ir[7:0];
  assign unused_ir    = ir[11:8];
  assign mem.mem_req  = req_q;
  assign mem.mem_addr = pc;

  always_comb begin
    alu_op = 3'b000;
    case (opcode)
      OP_ADD:  alu_op = 3'b000;
      OP_SUB:  alu_op = 3'b001;
      OP_LOAD: alu_op = 3'b010;
      default: alu_op = 3'b000;
    endcase
  end

  always_comb begin
    next_pc = pc + 1'b1;
    case (opcode)
      OP_JMP:  next_pc = ADDR_W'(operand);
      OP_JZ:   if (zero_flag) next_pc = ADDR_W'(operand);
      default: ;
    endcase
  end

`ifdef SINGLE_STEP_EN
  logic step_d;
`else
  logic unused_step;
  assign unused_step = step;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      ir            <= '0;
      req_q         <= 1'b0;
      wait_cnt      <= '0;
      acc_load      <= 1'b0;
      halted        <= 1'b0;
      fault         <= 1'b0;
      instr_retired <= '0;
`ifdef SINGLE_STEP_EN
      step_d        <= 1'b0;
`endif
    end else begin
      acc_load <= 1'b0;
`ifdef SINGLE_STEP_EN
      step_d   <= step;
`endif
      case (state)
        IDLE: begin
          if (run) begin
            state    <= FETCH;
            req_q    <= 1'b1;
            wait_cnt <= TO_LOAD;
          end
        end
        FETCH: begin
          // An ack on the terminal-count cycle still wins over the timeout.
          if (mem.mem_ack) begin
            ir    <= mem.mem_rdata;
            req_q <= 1'b0;
            state <= DECODE;
          end else if (TO_EN && wait_cnt == '0) begin
            req_q <= 1'b0;
            fault <= 1'b1;
            state <= FAULT;
          end else if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        DECODE: begin
          acc_load <= (opcode == OP_LOAD) || (opcode == OP_ADD) || (opcode == OP_SUB);
          state    <= EXEC;
        end
        EXEC: begin
          if (opcode == OP_HLT) begin
            halted <= 1'b1;
            state  <= HALT;
          end else begin
            pc            <= next_pc;
            instr_retired <= instr_retired + 16'd1;
`ifdef SINGLE_STEP_EN
            state         <= PAUSE;
`else
            state         <= run ? FETCH : IDLE;
            req_q         <= run;
            wait_cnt      <= TO_LOAD;
`endif
          end
        end
`ifdef SINGLE_STEP_EN
        PAUSE: begin
          if (step && !step_d) begin
            state    <= run ? FETCH : IDLE;
            req_q    <= run;
            wait_cnt <= TO_LOAD;
          end
        end
`endif
        HALT, FAULT: req_q <= 1'b0;
        default:     state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: vector table, hand-written corner cases and random programs.
module tb_cpu_sequencer;
  logic        clk = 1'b0;
  logic        reset, run, zero_flag, step;
  logic [7:0]  pc, operand;
  logic [2:0]  alu_op;
  logic        acc_load, halted, fault;
  logic [15:0] instr_retired;

  cpu_sequencer_if #(.ADDR_W(8)) mem_if();

  cpu_sequencer #(.ADDR_W(8), .RESET_PC(8'h00), .FETCH_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .run(run), .mem(mem_if), .zero_flag(zero_flag), .step(step),
    .pc(pc), .operand(operand), .alu_op(alu_op), .acc_load(acc_load), .halted(halted),
    .fault(fault), .instr_retired(instr_retired)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [15:0] imem [256];
  int   lat, wait_n, cyc, last_ack_cyc, ack_cnt, load_cnt;
  logic [7:0] last_ack_addr, last_opnd;
  logic [2:0] last_op;
  bit   mem_en, spur, rand_lat, sb_en, zf_ovr, zf_val, auto_step;
  logic [7:0] dp_acc, m_pc, m_acc;
  int   m_ret;
  bit   m_halt;

  typedef struct {
    logic [7:0]  start;
    logic [15:0] instr;
    bit          zf;
    logic [7:0]  exp_pc;
    int          exp_ret;
    int          exp_loads;
    logic [2:0]  exp_op;
    bit          exp_halt;
  } vec_t;
  vec_t vecs [10];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Instruction-level reference: one call per fetched instruction.
  task automatic model_step(logic [7:0] addr);
    logic [15:0] ins;
    logic [7:0]  op8;
    check("sb_fetch_addr", addr, m_pc);
    ins = imem[addr];
    op8 = ins[7:0];
    if (ins[15:12] == 4'hF) begin
      m_halt = 1;
    end else begin
      case (ins[15:12])
        4'h1: begin m_acc = op8;         m_pc = m_pc + 8'd1; end
        4'h2: begin m_acc = m_acc + op8; m_pc = m_pc + 8'd1; end
        4'h3: begin m_acc = m_acc - op8; m_pc = m_pc + 8'd1; end
        4'h4: m_pc = op8;
        4'h5: m_pc = (m_acc == 8'd0) ? op8 : m_pc + 8'd1;
        default: m_pc = m_pc + 8'd1;
      endcase
      m_ret++;
    end
  endtask

  // Accumulator/ALU datapath driven by the sequencer strobes.
  always @(posedge clk or posedge reset) begin
    if (reset) dp_acc <= 8'h00;
    else if (acc_load) begin
      case (alu_op)
        3'b000:  dp_acc <= dp_acc + operand;
        3'b001:  dp_acc <= dp_acc - operand;
        3'b010:  dp_acc <= operand;
        default: dp_acc <= dp_acc;
      endcase
    end
  end
  assign zero_flag = zf_ovr ? zf_val : (dp_acc == 8'h00);

  always @(negedge clk) if (auto_step) step = ~step;

  // Memory responder and strobe monitor.
  always @(negedge clk) begin
    cyc++;
    if (acc_load) begin
      load_cnt++;
      last_op   = alu_op;
      last_opnd = operand;
      check("acc_load_latency", cyc - last_ack_cyc, 2);
    end
    mem_if.mem_ack = 1'b0;
    if (reset) begin
      wait_n = 0;
    end else if (mem_if.mem_req && mem_en) begin
      if (wait_n >= lat) begin
        mem_if.mem_ack   = 1'b1;
        mem_if.mem_rdata = imem[mem_if.mem_addr];
        ack_cnt++;
        last_ack_cyc  = cyc;
        last_ack_addr = mem_if.mem_addr;
        wait_n = 0;
        if (sb_en) model_step(mem_if.mem_addr);
        if (rand_lat) lat = $urandom_range(0, 4);
      end else begin
        wait_n++;
      end
    end else begin
      wait_n = 0;
      if (spur && !mem_if.mem_req && ($urandom_range(0, 2) == 0)) begin
        mem_if.mem_ack   = 1'b1;
        mem_if.mem_rdata = 16'hF000;
      end
    end
  end

  task automatic tick(int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic do_reset();
    run = 1'b0;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    ack_cnt = 0;
    load_cnt = 0;
    last_ack_cyc = -100;
    tick(1);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int req_cyc, bad, a0;
    logic [3:0] rop;
    reset = 1'b1; run = 1'b0; step = 1'b0;
    mem_if.mem_ack = 1'b0; mem_if.mem_rdata = 16'h0000;
    lat = 0; wait_n = 0; cyc = 0; ack_cnt = 0; load_cnt = 0; last_ack_cyc = -100;
    mem_en = 1; spur = 0; rand_lat = 0; sb_en = 0; zf_ovr = 0; zf_val = 0; auto_step = 1;
    m_pc = 0; m_acc = 0; m_ret = 0; m_halt = 0;
    clear_mem();

    vecs[0] = '{8'h07, 16'h5033, 1'b0, 8'h08, 2, 0, 3'b000, 1'b0};
    vecs[1] = '{8'h07, 16'h5033, 1'b1, 8'h33, 2, 0, 3'b000, 1'b0};
    vecs[2] = '{8'hFF, 16'h4000, 1'b0, 8'h00, 2, 0, 3'b000, 1'b0};
    vecs[3] = '{8'hFF, 16'h0000, 1'b0, 8'h00, 2, 0, 3'b000, 1'b0};
    vecs[4] = '{8'hFF, 16'h6A12, 1'b0, 8'h00, 2, 0, 3'b000, 1'b0};
    vecs[5] = '{8'h10, 16'h105A, 1'b0, 8'h11, 2, 1, 3'b010, 1'b0};
    vecs[6] = '{8'h20, 16'h2003, 1'b0, 8'h21, 2, 1, 3'b000, 1'b0};
    vecs[7] = '{8'h30, 16'h3008, 1'b0, 8'h31, 2, 1, 3'b001, 1'b0};
    vecs[8] = '{8'h04, 16'hF000, 1'b0, 8'h04, 1, 0, 3'b000, 1'b1};
    vecs[9] = '{8'h05, 16'h4005, 1'b0, 8'h05, 2, 0, 3'b000, 1'b0};

    // Reset state
    tick(1);
    check("rst_pc", pc, 8'h00);
    check("rst_req", mem_if.mem_req, 1'b0);
    check("rst_acc_load", acc_load, 1'b0);
    check("rst_alu_op", alu_op, 3'b000);
    check("rst_operand", operand, 8'h00);
    check("rst_halted", halted, 1'b0);
    check("rst_fault", fault, 1'b0);
    check("rst_retired", instr_retired, 16'h0000);

    // Single-instruction vectors: JMP from 0 to the start address, then the instruction under test.
    for (int v = 0; v < 10; v++) begin
      clear_mem();
      imem[0] = {8'h40, vecs[v].start};
      imem[vecs[v].start] = vecs[v].instr;
      zf_ovr = 1; zf_val = vecs[v].zf; lat = 1;
      do_reset();
      run = 1'b1;
      for (int i = 0; i < 60 && ack_cnt < 2; i++) tick(1);
      run = 1'b0;
      check("vec_ack_wait", ack_cnt >= 2, 1'b1);
      tick(10);
      check("vec_pc", pc, vecs[v].exp_pc);
      check("vec_retired", instr_retired, vecs[v].exp_ret);
      check("vec_halted", halted, vecs[v].exp_halt);
      check("vec_loads", load_cnt, vecs[v].exp_loads);
      if (vecs[v].exp_loads > 0) begin
        check("vec_alu_op", last_op, vecs[v].exp_op);
        check("vec_operand", last_opnd, vecs[v].instr[7:0]);
      end
    end
    zf_ovr = 0; lat = 0;

    // LOAD 5, ADD 3, SUB 8, JZ 0x10, then HLT at 0x10.
    clear_mem();
    imem[0] = 16'h1005; imem[1] = 16'h2003; imem[2] = 16'h3008; imem[3] = 16'h5010;
    imem[8'h10] = 16'hF000;
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 200 && !halted; i++) tick(1);
    check("prog_halted", halted, 1'b1);
    check("prog_pc", pc, 8'h10);
    check("prog_retired", instr_retired, 16'd4);
    check("prog_loads", load_cnt, 3);
    check("prog_acc", dp_acc, 8'h00);
    check("prog_last_op", last_op, 3'b001);
    // Halted core ignores stray acks and never requests again.
    spur = 1; req_cyc = 0;
    for (int i = 0; i < 20; i++) begin tick(1); if (mem_if.mem_req) req_cyc++; end
    spur = 0;
    check("halt_no_req", req_cyc, 0);
    check("halt_pc_held", pc, 8'h10);
    check("halt_retired_held", instr_retired, 16'd4);
    run = 1'b0;

    // Ack delayed 3 cycles: four request cycles at a stable address, one IR load.
    clear_mem();
    lat = 3;
    do_reset();
    run = 1'b1;
    req_cyc = 0; bad = 0;
    for (int i = 0; i < 20 && ack_cnt == 0; i++) begin
      tick(1);
      if (mem_if.mem_req) req_cyc++;
      if (mem_if.mem_req && mem_if.mem_addr != 8'h00) bad++;
    end
    run = 1'b0;
    check("delay_req_cycles", req_cyc, 4);
    check("delay_addr_stable", bad, 0);
    tick(1);
    check("delay_req_drop", mem_if.mem_req, 1'b0);
    check("delay_one_load", ack_cnt, 1);
    lat = 0;

    // Ack withheld: fault after 16 request cycles, held until reset.
    mem_en = 0;
    do_reset();
    run = 1'b1;
    req_cyc = 0;
    for (int i = 0; i < 40 && !fault; i++) begin
      tick(1);
      if (mem_if.mem_req) req_cyc++;
    end
    check("to_req_cycles", req_cyc, 16);
    check("to_fault", fault, 1'b1);
    check("to_req_low", mem_if.mem_req, 1'b0);
    mem_en = 1; spur = 1; req_cyc = 0;
    for (int i = 0; i < 10; i++) begin tick(1); if (mem_if.mem_req) req_cyc++; end
    spur = 0;
    check("to_fault_held", fault, 1'b1);
    check("to_no_req_after", req_cyc, 0);
    check("to_retired", instr_retired, 16'd0);
    do_reset();
    check("to_reset_clears", fault, 1'b0);

    // Reset mid-fetch drops mem_req immediately and restores RESET_PC.
    clear_mem();
    imem[0] = 16'h4040;
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 20 && ack_cnt < 1; i++) tick(1);
    lat = 10;
    for (int i = 0; i < 20 && !(mem_if.mem_req && pc == 8'h40); i++) tick(1);
    check("midfetch_reached", pc, 8'h40);
    tick(2);
    reset = 1'b1;
    #1;
    check("midfetch_req", mem_if.mem_req, 1'b0);
    check("midfetch_pc", pc, 8'h00);
    check("midfetch_operand", operand, 8'h00);
    tick(1);
    reset = 1'b0; run = 1'b0; lat = 0;
    tick(1);

    // run drops during EXEC of ADD: instruction completes, core idles, resumes at next pc.
    clear_mem();
    imem[0] = 16'h1001; imem[1] = 16'h2002;
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 100 && !(acc_load && alu_op == 3'b000); i++) tick(1);
    check("runlow_add_exec", acc_load, 1'b1);
    run = 1'b0;
    req_cyc = 0;
    for (int i = 0; i < 10; i++) begin tick(1); if (mem_if.mem_req) req_cyc++; end
    check("runlow_no_req", req_cyc, 0);
    check("runlow_pc", pc, 8'h02);
    check("runlow_retired", instr_retired, 16'd2);
    check("runlow_acc", dp_acc, 8'h03);
    a0 = ack_cnt;
    run = 1'b1;
    for (int i = 0; i < 20 && ack_cnt == a0; i++) tick(1);
    check("runlow_resume_addr", last_ack_addr, 8'h02);
    run = 1'b0;
    tick(10);

`ifdef SINGLE_STEP_EN
    // One step edge retires exactly one instruction.
    auto_step = 0; step = 1'b0;
    clear_mem();
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 20 && ack_cnt < 1; i++) tick(1);
    tick(10);
    check("ss_paused_retired", instr_retired, 16'd1);
    check("ss_paused_req", mem_if.mem_req, 1'b0);
    step = 1'b1; tick(3); step = 1'b0;
    tick(10);
    check("ss_one_step", instr_retired, 16'd2);
    run = 1'b0; auto_step = 1;
    tick(5);
`endif

    // Random programs against the instruction-level model.
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < 256; i++) begin
        int r;
        r = $urandom_range(0, 39);
        rop = (r == 0) ? 4'hF : 4'(r % 7);
        imem[i] = {rop, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255))};
      end
      m_pc = 8'h00; m_acc = 8'h00; m_ret = 0; m_halt = 0;
      rand_lat = 1; spur = 1;
      do_reset();
      sb_en = 1;
      run = 1'b1;
      for (int i = 0; i < 3000 && instr_retired < 16'd40 && !halted; i++) tick(1);
      run = 1'b0;
      tick(20);
      check("rnd_progress", (instr_retired >= 16'd40) || halted, 1'b1);
      check("rnd_retired", instr_retired, m_ret);
      check("rnd_pc", pc, m_pc);
      check("rnd_halted", halted, m_halt);
      check("rnd_acc", dp_acc, m_acc);
      check("rnd_idle_req", mem_if.mem_req, 1'b0);
      sb_en = 0; rand_lat = 0; spur = 0; lat = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
